// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolver: funct3 encodings and FSM states.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } br_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational funct3 decode: selects the branch condition from the comparator
// flags, flags reserved encodings and drives the unsigned-compare select.
module br_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       BrEq,
    input  logic       BrLt,
    output logic       cond,
    output logic       illegal,
    output logic       BrUn
);

    logic [7:0] cond_vec;

    // One condition per funct3 code; reserved codes resolve to not-taken.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_f3
            localparam logic [2:0] F3 = 3'(gi);
            if (F3 == F3_BEQ) begin : g_eq
                assign cond_vec[gi] = BrEq;
            end else if (F3 == F3_BNE) begin : g_ne
                assign cond_vec[gi] = ~BrEq;
            end else if (F3 == F3_BLT || F3 == F3_BLTU) begin : g_lt
                assign cond_vec[gi] = BrLt;
            end else if (F3 == F3_BGE || F3 == F3_BGEU) begin : g_ge
                assign cond_vec[gi] = ~BrLt;
            end else begin : g_rsvd
                assign cond_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign cond    = cond_vec[funct3];
    assign illegal = (funct3[2:1] == 2'b01);
    assign BrUn    = funct3[1];

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolver with redirect handshake and wrong-path flush.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = N'(32'h0000_2000)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_valid,
    input  logic         ex_is_branch,
    input  logic         ex_is_jal,
    input  logic         ex_is_jalr,
    input  logic [2:0]   ex_funct3,
    input  logic         BrEq,
    input  logic         BrLt,
    input  logic [N-1:0] ex_target,
    output logic         BrUn,
    output logic         redirect_valid,
    input  logic         redirect_ready,
    output logic [N-1:0] redirect_pc,
    output logic         flush,
    output logic         ex_stall,
    output logic         misalign,
    output logic         illegal_br
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]  br_count,
    output logic [31:0]  br_taken_count
`endif
);

    br_state_t    state_reg, state_next;
    logic [N-1:0] redirect_pc_reg, redirect_pc_next;
    logic         misalign_reg, misalign_next;
    logic         illegal_reg, illegal_next;

    logic cond;
    logic f3_illegal;
    logic br_sel;
    logic taken;
    logic aligned;

    br_cond_eval u_cond_eval (
        .funct3  (ex_funct3),
        .BrEq    (BrEq),
        .BrLt    (BrLt),
        .cond    (cond),
        .illegal (f3_illegal),
        .BrUn    (BrUn)
    );

    // Jumps win over a simultaneously flagged branch, so only a pure branch can be illegal.
    assign br_sel  = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    assign taken   = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond));
    assign aligned = (ex_target[1:0] == 2'b00);

    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        misalign_next    = 1'b0;
        illegal_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (taken && aligned) begin
                    state_next       = REDIR;
                    redirect_pc_next = ex_target;
                end
                misalign_next = taken & ~aligned;
                illegal_next  = ex_valid & br_sel & f3_illegal;
            end
            REDIR: begin
                // EX holds wrong-path contents here; only the handshake matters.
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            redirect_pc_reg <= RESET_PC;
            misalign_reg    <= 1'b0;
            illegal_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            redirect_pc_reg <= redirect_pc_next;
            misalign_reg    <= misalign_next;
            illegal_reg     <= illegal_next;
        end
    end

    assign redirect_valid = (state_reg == REDIR);
    assign flush          = (state_reg == REDIR);
    assign ex_stall       = (state_reg == REDIR) & ~redirect_ready;
    assign redirect_pc    = redirect_pc_reg;
    assign misalign       = misalign_reg;
    assign illegal_br     = illegal_reg;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] br_count_reg, br_count_next;
    logic [31:0] br_taken_count_reg, br_taken_count_next;
    logic        idle_cf;
    logic        idle_taken;

    assign idle_cf    = (state_reg == IDLE) & ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    assign idle_taken = (state_reg == IDLE) & taken;

    always_comb begin
        br_count_next       = br_count_reg + 32'(idle_cf);
        br_taken_count_next = br_taken_count_reg + 32'(idle_taken);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count_reg       <= 32'd0;
            br_taken_count_reg <= 32'd0;
        end else begin
            br_count_reg       <= br_count_next;
            br_taken_count_reg <= br_taken_count_next;
        end
    end

    assign br_count       = br_count_reg;
    assign br_taken_count = br_taken_count_reg;
`endif

endmodule
